ahb_sram_2k_ctrl: RTL and testbench

AHB-Lite slave front end that owns one 2 KB single-port SRAM macro wrapper (512x32, active-low write enable, 1-cycle synchronous read, no byte enables).
- Converts AHB-Lite transfers into SRAM cs/wen/addr/data strobes.
- Byte and halfword writes use read-modify-write, because the macro has no byte enables.
- Illegal transfers (bad size or misaligned) get the standard two-cycle ERROR response.
- Sits between an AHB matrix slave port and the SRAM wrapper in the MCU memory subsystem.

---
 rtl/ahb_sram_pkg.sv | 27 ++
 rtl/ahb_sram_2k_ctrl_if.sv | 23 ++
 rtl/ahb_sram_lane_merge.sv | 29 ++
 rtl/ahb_sram_2k_ctrl.sv | 107 ++++++++++
 tb/tb_ahb_sram_2k_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared types and AHB-Lite encodings for the 2 KB SRAM controller.
package ahb_sram_pkg;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_DATA, WR, RMW_RD, RMW_WR, ERR1, ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Oversized or misaligned transfers are answered with ERROR.
  function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] lo);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_HALF) && lo[0]) ||
           ((size == HSIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_sram_2k_ctrl_if.sv
// AHB-Lite slave-port bundle between the matrix and the SRAM controller.
interface ahb_sram_2k_ctrl_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_lane_merge.sv
// Byte-lane mask from size/offset, and the read-modify-write byte merge.
module ahb_sram_lane_merge
  import ahb_sram_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [3:0]  mask,
  input  logic [3:0]  merge_mask,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged
);

  always_comb begin
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
  end

  always_comb begin
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (merge_mask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_sram_2k_ctrl.sv
// AHB-Lite slave owning a 512x32 single-port SRAM; sub-word writes are done
// as read-modify-write because the macro has no byte enables.
module ahb_sram_2k_ctrl
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ahb_sram_2k_ctrl_if.slave     ahb,
  output logic                  sram_cs,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_t                  state;
  state_t                  acc_state;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic                    write_p1;
  logic [2:0]              size_p1;
  logic [1:0]              lane_p1;
  logic [3:0]              mask_p1;
  logic [DATA_WIDTH-1:0]   wdata_p2;
  logic [3:0]              mask_c;
  logic [31:0]             merged;
  logic                    hready_c;
  logic                    accept;
  logic                    unused_ok;

  ahb_sram_lane_merge u_merge (
    .size       (ahb.hsize),
    .addr_lo    (ahb.haddr[1:0]),
    .mask       (mask_c),
    .merge_mask (mask_p1),
    .wdata      (wdata_p2),
    .rdata      (sram_q),
    .merged     (merged)
  );

  assign accept = ahb.hsel & ahb.htrans[1] & ahb.hready & hready_c;

  always_comb begin
    if (xfer_illegal(ahb.hsize, ahb.haddr[1:0])) acc_state = ERR1;
    else if (!ahb.hwrite)                        acc_state = RD_ISSUE;
    else if (ahb.hsize == HSIZE_WORD)            acc_state = WR;
    else                                         acc_state = RMW_RD;
  end

  // Address phase -> control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_p1  <= '0;
      write_p1 <= 1'b0;
      size_p1  <= '0;
      lane_p1  <= '0;
      mask_p1  <= '0;
    end else begin
      if (accept) begin
        addr_p1  <= ahb.haddr[ADDR_WIDTH+1:2];
        write_p1 <= ahb.hwrite;
        size_p1  <= ahb.hsize;
        lane_p1  <= ahb.haddr[1:0];
        mask_p1  <= mask_c;
      end
      case (state)
        RD_ISSUE: state <= RD_DATA;
        RMW_RD:   state <= RMW_WR;
        ERR1:     state <= ERR2;
        default:  state <= accept ? acc_state : IDLE;
      endcase
    end
  end

  // Data phase capture: the master holds hwdata through the RMW wait state
  always_ff @(posedge clk) begin
    if (state == RMW_RD) wdata_p2 <= ahb.hwdata;
  end

  always_comb begin
    hready_c  = 1'b1;
    ahb.hresp = HRESP_OKAY;
    sram_cs   = 1'b0;
    sram_wen  = 1'b1;
    sram_data = '0;
    case (state)
      RD_ISSUE: begin sram_cs = 1'b1; hready_c = 1'b0; end
      WR:       begin sram_cs = 1'b1; sram_wen = 1'b0; sram_data = ahb.hwdata; end
      RMW_RD:   begin sram_cs = 1'b1; hready_c = 1'b0; end
      RMW_WR:   begin sram_cs = 1'b1; sram_wen = 1'b0; sram_data = merged; end
      ERR1:     begin ahb.hresp = HRESP_ERROR; hready_c = 1'b0; end
      ERR2:     ahb.hresp = HRESP_ERROR;
      default:  ;
    endcase
  end

  assign ahb.hreadyout = hready_c;
  assign ahb.hrdata    = sram_q;
  assign sram_addr     = addr_p1;

  // Upper address bits alias; the size/lane/write copies are kept for debug visibility.
  assign unused_ok = ^{ahb.haddr[31:ADDR_WIDTH+2], write_p1, size_p1, lane_p1};

endmodule

// File: tb/tb_ahb_sram_2k_ctrl.sv
// Directed scoreboard bench for ahb_sram_2k_ctrl with a behavioural 512x32 SRAM.
module tb_ahb_sram_2k_ctrl;
  import ahb_sram_pkg::*;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sram_cs, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_data, sram_q;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;
  logic [31:0]   mem [0:511];

  always #5 clk = ~clk;

  ahb_sram_2k_ctrl_if bus ();
  assign bus.hready = bus.hreadyout;

  ahb_sram_2k_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ahb       (bus),
    .sram_cs   (sram_cs),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_q    (sram_q)
  );

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (sram_cs) begin
      if (!sram_wen) mem[sram_addr] <= sram_data;
      else           sram_q <= mem[sram_addr];
    end
  end

  typedef struct {
    logic        is_read;
    logic        err;
    logic [31:0] rdata;
    int          waits;
    int          tag;
  } resp_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  resp_t r;
  wr_t   w;
  int    n_checks = 0;
  int    n_fail = 0;
  int    cs_count = 0;
  int    tag_n = 0;
  bit    dp_active = 1'b0;
  int    waits = 0;
  logic  first_resp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: pops expectations as SRAM write strobes and completed data phases appear
  always @(negedge clk) begin
    if (rst) begin
      dp_active = 1'b0;
      waits = 0;
    end else begin
      if (sram_cs) cs_count++;
      if (sram_cs && !sram_wen) begin
        if (wq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected", sram_addr, sram_data);
        end else begin
          w = wq.pop_front();
          check("wr_addr", 32'(sram_addr), 32'(w.addr));
          check("wr_data", sram_data, w.data);
        end
      end
      if (dp_active && !bus.hreadyout) begin
        if (waits == 0) first_resp = bus.hresp;
        waits++;
      end
      if (bus.hreadyout) begin
        if (dp_active) begin
          if (rq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_resp: hresp %0b, no response expected", bus.hresp);
          end else begin
            r = rq.pop_front();
            check($sformatf("resp%0d_waits", r.tag), waits, r.waits);
            check($sformatf("resp%0d_hresp", r.tag), 32'(bus.hresp), 32'(r.err));
            if (r.waits > 0)
              check($sformatf("resp%0d_wait_hresp", r.tag), 32'(first_resp), 32'(r.err));
            if (r.is_read && !r.err)
              check($sformatf("resp%0d_hrdata", r.tag), bus.hrdata, r.rdata);
          end
        end
        dp_active = bus.hsel && bus.htrans[1];
        waits = 0;
      end
    end
  end

  task automatic exp_resp(input logic rd, input logic err, input int nw, input logic [31:0] rdata);
    resp_t e;
    e.is_read = rd; e.err = err; e.waits = nw; e.rdata = rdata; e.tag = tag_n;
    tag_n++;
    rq.push_back(e);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    wq.push_back(e);
  endtask

  task automatic wait_ready();
    int   n = 0;
    logic ok;
    do begin
      @(negedge clk); ok = bus.hreadyout;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL bus_timeout: hreadyout %0b after %0d cycles, required 1", ok, n);
    end
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] s,
                            input logic [31:0] wd);
    bus.hsel = 1'b1; bus.haddr = a; bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = wr; bus.hsize = s;
    wait_ready();
    if (wr) bus.hwdata = wd;
  endtask

  task automatic bus_idle();
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
    wait_ready();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bus.hsel = 1'b1; bus.haddr = 32'h4; bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = 1'b1; bus.hsize = HSIZE_WORD; bus.hwdata = 32'h0;
    rst = 1'b1;

    // Reset with an active transfer on the bus
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ctrl", 32'({bus.hreadyout, bus.hresp, sram_cs, sram_wen}), 32'b1001);
      check("rst_addr", 32'(sram_addr), 32'h0);
      check("rst_data", sram_data, 32'h0);
    end
    preload(9'd2, 32'h11223344);
    preload(9'd3, 32'h55667788);
    preload(9'd5, 32'hCAFEF00D);
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'({bus.hreadyout, sram_cs}), 32'b10);
    @(posedge clk); #1;

    // Word write then back-to-back read
    c0 = cs_count;
    exp_wr(9'd1, 32'hDEADBEEF); exp_resp(1'b0, 1'b0, 0, 32'h0);
    addr_phase(32'h004, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
    exp_resp(1'b1, 1'b0, 1, 32'hDEADBEEF);
    addr_phase(32'h004, 1'b0, HSIZE_WORD, 32'h0);
    bus_idle();
    check("word_cs_cycles", cs_count - c0, 2);

    // Byte RMW into lane 2, then read back
    c0 = cs_count;
    exp_wr(9'd2, 32'h11AA3344); exp_resp(1'b0, 1'b0, 1, 32'h0);
    addr_phase(32'h00A, 1'b1, HSIZE_BYTE, 32'h99AA5566);
    exp_resp(1'b1, 1'b0, 1, 32'h11AA3344);
    addr_phase(32'h008, 1'b0, HSIZE_WORD, 32'h0);
    bus_idle();
    check("byte_cs_cycles", cs_count - c0, 3);

    // Halfword RMW into upper lanes
    exp_wr(9'd3, 32'hBEEF7788); exp_resp(1'b0, 1'b0, 1, 32'h0);
    addr_phase(32'h00E, 1'b1, HSIZE_HALF, 32'hBEEF1234);
    exp_resp(1'b1, 1'b0, 1, 32'hBEEF7788);
    addr_phase(32'h00C, 1'b0, HSIZE_WORD, 32'h0);
    bus_idle();

    // Illegal transfers, back to back
    c0 = cs_count;
    exp_resp(1'b0, 1'b1, 1, 32'h0);
    addr_phase(32'h002, 1'b1, HSIZE_WORD, 32'h12345678);
    exp_resp(1'b1, 1'b1, 1, 32'h0);
    addr_phase(32'h000, 1'b0, 3'd3, 32'h0);
    exp_resp(1'b0, 1'b1, 1, 32'h0);
    addr_phase(32'h001, 1'b1, HSIZE_HALF, 32'h0);
    bus_idle();
    check("err_cs_cycles", cs_count - c0, 0);

    // Legal read accepted in the second ERROR cycle
    exp_resp(1'b1, 1'b1, 1, 32'h0);
    addr_phase(32'h000, 1'b0, 3'd5, 32'h0);
    exp_resp(1'b1, 1'b0, 1, 32'hDEADBEEF);
    addr_phase(32'h004, 1'b0, HSIZE_WORD, 32'h0);
    bus_idle();

    // Address aliasing above 2 KB
    exp_wr(9'd0, 32'h0BADF00D); exp_resp(1'b0, 1'b0, 0, 32'h0);
    addr_phase(32'h800, 1'b1, HSIZE_WORD, 32'h0BADF00D);
    exp_resp(1'b1, 1'b0, 1, 32'h0BADF00D);
    addr_phase(32'h000, 1'b0, HSIZE_WORD, 32'h0);
    bus_idle();

    // Reset asserted while the RMW read is in flight
    addr_phase(32'h015, 1'b1, HSIZE_BYTE, 32'h00007700);
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
    @(negedge clk);
    check("rmw_rd_strobe", 32'({sram_cs, sram_wen, bus.hreadyout}), 32'b110);
    #1 rst = 1'b1;
    #1 check("rst_midop", 32'({sram_cs, sram_wen, bus.hreadyout}), 32'b011);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_resp(1'b1, 1'b0, 1, 32'hCAFEF00D);
    addr_phase(32'h014, 1'b0, HSIZE_WORD, 32'h0);
    bus_idle();

    repeat (3) @(posedge clk);
    check("resp_queue_empty", rq.size(), 0);
    check("write_queue_empty", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
